// File: rtl/noc_packetizer_pkg.sv
// Shared definitions for the NoC injection path and the router head-flit decoder.
// Contents: flit type encoding, packetizer FSM states, width derivations and
// head-flit payload field offsets (LSB-first: dst_x, dst_y, src_x, src_y, len).
package noc_packetizer_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY      = 2'd0,
    FLIT_HEAD      = 2'd1,
    FLIT_TAIL      = 2'd2,
    FLIT_HEAD_TAIL = 2'd3
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } pkt_state_e;

  // A single VC still needs one bit in the flit so the field never vanishes.
  function automatic int calc_vc_w(input int vc_num);
    return (vc_num > 1) ? $clog2(vc_num) : 1;
  endfunction

  function automatic int calc_len_w(input int max_body);
    return $clog2(max_body + 1);
  endfunction

  function automatic int hdr_dst_x_lsb();
    return 0;
  endfunction

  function automatic int hdr_dst_y_lsb(input int xw);
    return xw;
  endfunction

  function automatic int hdr_src_x_lsb(input int xw, input int yw);
    return xw + yw;
  endfunction

  function automatic int hdr_src_y_lsb(input int xw, input int yw);
    return 2 * xw + yw;
  endfunction

  function automatic int hdr_len_lsb(input int xw, input int yw);
    return 2 * xw + 2 * yw;
  endfunction

endpackage

// File: rtl/noc_out_reg.sv
// Single-entry valid/ready output register.
// Ports:
//   clk, srst     - clock, synchronous active-high reset
//   load_i        - capture data_i this cycle (caller only asserts when slot_free_o)
//   data_i        - word to capture
//   ready_i       - downstream accepts the held word
//   valid_o       - held word is valid
//   data_o        - held word, stable until consumed
//   slot_free_o   - register empty or being drained this cycle
module noc_out_reg #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             slot_free_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Draining and refilling in the same cycle gives one flit per clock.
  assign slot_free_o = !valid_q || ready_i;
  assign valid_o     = valid_q;
  assign data_o      = data_q;

endmodule

// File: rtl/noc_packetizer.sv
// NoC injection stage: turns a (dst, len) descriptor plus a payload word stream
// into a wormhole packet (head flit, then len body/tail flits) on one VC.
// Ports:
//   noc_clk, noc_rst        - clock, synchronous active-high reset
//   id_x, id_y              - own coordinates (static), placed in the head as source
//   msg_valid/ready         - descriptor handshake; msg_dst_x/y, msg_len
//   data_valid/ready, data  - payload word handshake
//   out_valid/ready         - flit handshake toward router local port
//   out_flit                - {type[1:0], vc, payload}
//   out_vc_ready            - per-VC downstream buffer availability
module noc_packetizer
  import noc_packetizer_pkg::*;
#(
  parameter int NOC_ID_X_WIDTH = 2,
  parameter int NOC_ID_Y_WIDTH = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int VC_NUM         = 2,
  parameter int MAX_BODY       = 8,
  localparam int VC_W          = calc_vc_w(VC_NUM),
  localparam int LEN_W         = calc_len_w(MAX_BODY),
  localparam int FLIT_W        = 2 + VC_W + DATA_WIDTH
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [NOC_ID_X_WIDTH-1:0] id_x,
  input  logic [NOC_ID_Y_WIDTH-1:0] id_y,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  logic [NOC_ID_X_WIDTH-1:0] msg_dst_x,
  input  logic [NOC_ID_Y_WIDTH-1:0] msg_dst_y,
  input  logic [LEN_W-1:0]          msg_len,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FLIT_W-1:0]         out_flit,
  input  logic [VC_NUM-1:0]         out_vc_ready
);

  localparam int HDR_DST_X = hdr_dst_x_lsb();
  localparam int HDR_DST_Y = hdr_dst_y_lsb(NOC_ID_X_WIDTH);
  localparam int HDR_SRC_X = hdr_src_x_lsb(NOC_ID_X_WIDTH, NOC_ID_Y_WIDTH);
  localparam int HDR_SRC_Y = hdr_src_y_lsb(NOC_ID_X_WIDTH, NOC_ID_Y_WIDTH);
  localparam int HDR_LEN   = hdr_len_lsb(NOC_ID_X_WIDTH, NOC_ID_Y_WIDTH);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BODY);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  pkt_state_e                state_q, state_d;
  logic [NOC_ID_X_WIDTH-1:0] dst_x_q, dst_x_d;
  logic [NOC_ID_Y_WIDTH-1:0] dst_y_q, dst_y_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          count_q, count_d;
  logic [VC_W-1:0]           vc_q, vc_d;

  logic                      slot_free;
  logic                      flit_load;
  logic [FLIT_W-1:0]         flit_d;
  logic [VC_W-1:0]           pick_vc;
  logic                      vc_any;
  logic                      head_go;
  logic                      msg_fire;
  logic                      data_fire;
  logic [DATA_WIDTH-1:0]     head_payload;
  flit_type_e                flit_type;

  // Lowest-index ready VC wins: scan high to low so the last hit is the lowest.
  always_comb begin
    pick_vc = '0;
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      if (out_vc_ready[i]) pick_vc = VC_W'(i);
    end
  end

  assign vc_any    = |out_vc_ready;
  assign head_go   = (state_q == ST_HEAD) && slot_free && vc_any;
  assign msg_fire  = msg_valid && msg_ready;
  assign data_fire = data_valid && data_ready;

  always_comb begin
    head_payload = '0;
    head_payload[HDR_DST_X +: NOC_ID_X_WIDTH] = dst_x_q;
    head_payload[HDR_DST_Y +: NOC_ID_Y_WIDTH] = dst_y_q;
    head_payload[HDR_SRC_X +: NOC_ID_X_WIDTH] = id_x;
    head_payload[HDR_SRC_Y +: NOC_ID_Y_WIDTH] = id_y;
    head_payload[HDR_LEN   +: LEN_W]          = len_q;
  end

  // State register
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q <= ST_IDLE;
      dst_x_q <= '0;
      dst_y_q <= '0;
      len_q   <= '0;
      count_q <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      dst_x_q <= dst_x_d;
      dst_y_q <= dst_y_d;
      len_q   <= len_d;
      count_q <= count_d;
      vc_q    <= vc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    len_d   = len_q;
    count_d = count_q;
    vc_d    = vc_q;
    case (state_q)
      ST_IDLE: begin
        if (msg_fire) begin
          dst_x_d = msg_dst_x;
          dst_y_d = msg_dst_y;
          // Out-of-range lengths are clamped so the body counter stays bounded.
          len_d   = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (head_go) begin
          vc_d = pick_vc;
          if (len_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            count_d = len_q;
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (data_fire) begin
          count_d = count_q - LEN_ONE;
          if (count_q == LEN_ONE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    msg_ready  = (state_q == ST_IDLE) && !noc_rst;
    // Body words wait for the packet's own VC; other ready VCs do not help.
    data_ready = (state_q == ST_BODY) && slot_free && out_vc_ready[vc_q] && !noc_rst;
    flit_load  = 1'b0;
    flit_type  = FLIT_BODY;
    flit_d     = '0;
    if (head_go) begin
      flit_load = 1'b1;
      flit_type = (len_q == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
      flit_d    = {flit_type, pick_vc, head_payload};
    end else if (data_fire) begin
      flit_load = 1'b1;
      flit_type = (count_q == LEN_ONE) ? FLIT_TAIL : FLIT_BODY;
      flit_d    = {flit_type, vc_q, data};
    end
  end

  noc_out_reg #(
    .WIDTH(FLIT_W)
  ) u_out_reg (
    .clk        (noc_clk),
    .srst       (noc_rst),
    .load_i     (flit_load),
    .data_i     (flit_d),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .data_o     (out_flit),
    .slot_free_o(slot_free)
  );

endmodule

// File: tb/tb_noc_packetizer.sv
module tb_noc_packetizer;

  localparam int XW  = 2;
  localparam int YW  = 2;
  localparam int DW  = 32;
  localparam int VCN = 2;
  localparam int MB  = 8;
  localparam int LW  = 4;
  localparam int FW  = 35;

  logic          noc_clk;
  logic          noc_rst;
  logic [XW-1:0] id_x;
  logic [YW-1:0] id_y;
  logic          msg_valid;
  logic          msg_ready;
  logic [XW-1:0] msg_dst_x;
  logic [YW-1:0] msg_dst_y;
  logic [LW-1:0] msg_len;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] data;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_flit;
  logic [VCN-1:0] out_vc_ready;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  noc_packetizer #(
    .NOC_ID_X_WIDTH(XW),
    .NOC_ID_Y_WIDTH(YW),
    .DATA_WIDTH    (DW),
    .VC_NUM        (VCN),
    .MAX_BODY      (MB)
  ) dut (
    .noc_clk     (noc_clk),
    .noc_rst     (noc_rst),
    .id_x        (id_x),
    .id_y        (id_y),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_dst_x   (msg_dst_x),
    .msg_dst_y   (msg_dst_y),
    .msg_len     (msg_len),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .data        (data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_flit    (out_flit),
    .out_vc_ready(out_vc_ready)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  // One line per accepted flit.
  always @(posedge noc_clk) begin
    if (!noc_rst && out_valid && out_ready) begin
      acc_cnt <= acc_cnt + 1;
      $display("flit type=%0d vc=%0d payload=%h", out_flit[34:33], out_flit[32], out_flit[31:0]);
    end
  end

  // Lengths above MAX_BODY are illegal stimulus.
  always @(posedge noc_clk) begin
    if (!noc_rst && msg_valid && msg_ready)
      assert (msg_len <= LW'(MB)) else $error("illegal msg_len %0d", msg_len);
  end

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic test_reset();
    noc_rst = 1'b1;
    msg_valid = 1'b0; msg_dst_x = '0; msg_dst_y = '0; msg_len = '0;
    data_valid = 1'b0; data = '0;
    out_ready = 1'b1; out_vc_ready = 2'b11;
    repeat (3) tick();
    checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL reset_msg_ready: got %b expected 0", msg_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_flit !== '0) begin errors++; $display("FAIL reset_out_flit: got %h expected 0", out_flit); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
    noc_rst = 1'b0;
    #1;
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_msg_ready: got %b expected 1", msg_ready); end
  endtask

  task automatic test_zero_len();
    msg_valid = 1'b1; msg_dst_x = 2'd2; msg_dst_y = 2'd3; msg_len = 4'd0;
    #1;
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL zl_msg_ready: got %b expected 1", msg_ready); end
    tick();
    msg_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zl_no_early_flit: got %b expected 0", out_valid); end
    checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL zl_head_msg_ready: got %b expected 0", msg_ready); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zl_valid: got %b expected 1", out_valid); end
    checks++; if (out_flit !== {2'b11, 1'b0, 32'h0000_001E}) begin errors++; $display("FAIL zl_flit: got %h expected %h", out_flit, {2'b11, 1'b0, 32'h0000_001E}); end
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL zl_back_idle: got %b expected 1", msg_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zl_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_three_word();
    logic [DW-1:0] words [3];
    logic [FW-1:0] exp;
    int a0;
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    a0 = acc_cnt;
    msg_valid = 1'b1; msg_dst_x = 2'd3; msg_dst_y = 2'd1; msg_len = 4'd3;
    tick();
    msg_valid = 1'b0;
    data_valid = 1'b1; data = words[0];
    #1;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL tw_data_ready_in_head: got %b expected 0", data_ready); end
    tick();
    checks++; if (out_flit !== {2'b01, 1'b0, 32'h0000_0317}) begin errors++; $display("FAIL tw_head: got %h expected %h", out_flit, {2'b01, 1'b0, 32'h0000_0317}); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL tw_data_ready_body: got %b expected 1", data_ready); end
    for (int i = 0; i < 3; i++) begin
      data = words[i];
      tick();
      exp = {(i == 2) ? 2'b10 : 2'b00, 1'b0, words[i]};
      checks++; if (out_valid !== 1'b1 || out_flit !== exp) begin errors++; $display("FAIL tw_body%0d: got v=%b %h expected v=1 %h", i, out_valid, out_flit, exp); end
    end
    data_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tw_drained: got %b expected 0", out_valid); end
    checks++; if (acc_cnt - a0 !== 4) begin errors++; $display("FAIL tw_count: got %0d expected 4", acc_cnt - a0); end
  endtask

  task automatic test_vc_select();
    out_vc_ready = 2'b00;
    msg_valid = 1'b1; msg_dst_x = 2'd0; msg_dst_y = 2'd2; msg_len = 4'd2;
    tick();
    msg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vc_stall%0d: got %b expected 0", i, out_valid); end
    end
    out_vc_ready = 2'b10;
    tick();
    checks++; if (out_valid !== 1'b1 || out_flit !== {2'b01, 1'b1, 32'h0000_0218}) begin errors++; $display("FAIL vc_head: got v=%b %h expected v=1 %h", out_valid, out_flit, {2'b01, 1'b1, 32'h0000_0218}); end
    data_valid = 1'b1; data = 32'h11; out_vc_ready = 2'b01;
    #1;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL vc_hold_ready1: got %b expected 0", data_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vc_hold_stall1: got %b expected 0", out_valid); end
    out_vc_ready = 2'b10;
    #1;
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL vc_resume_ready: got %b expected 1", data_ready); end
    tick();
    checks++; if (out_flit !== {2'b00, 1'b1, 32'h11}) begin errors++; $display("FAIL vc_body: got %h expected %h", out_flit, {2'b00, 1'b1, 32'h11}); end
    data = 32'h22; out_vc_ready = 2'b01;
    #1;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL vc_hold_ready2: got %b expected 0", data_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vc_hold_stall2: got %b expected 0", out_valid); end
    out_vc_ready = 2'b10;
    tick();
    checks++; if (out_flit !== {2'b10, 1'b1, 32'h22}) begin errors++; $display("FAIL vc_tail: got %h expected %h", out_flit, {2'b10, 1'b1, 32'h22}); end
    data_valid = 1'b0; out_vc_ready = 2'b11;
    tick();
  endtask

  task automatic test_backpressure();
    int a0;
    a0 = acc_cnt;
    msg_valid = 1'b1; msg_dst_x = 2'd1; msg_dst_y = 2'd1; msg_len = 4'd2;
    tick();
    msg_valid = 1'b0;
    data_valid = 1'b1; data = 32'h5A;
    tick();
    checks++; if (out_flit !== {2'b01, 1'b0, 32'h0000_0215}) begin errors++; $display("FAIL bp_head: got %h expected %h", out_flit, {2'b01, 1'b0, 32'h0000_0215}); end
    tick();
    checks++; if (out_flit !== {2'b00, 1'b0, 32'h5A}) begin errors++; $display("FAIL bp_body: got %h expected %h", out_flit, {2'b00, 1'b0, 32'h5A}); end
    out_ready = 1'b0; data = 32'h5B;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_flit !== {2'b00, 1'b0, 32'h5A}) begin errors++; $display("FAIL bp_hold%0d: got v=%b %h expected v=1 %h", i, out_valid, out_flit, {2'b00, 1'b0, 32'h5A}); end
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL bp_data_ready%0d: got %b expected 0", i, data_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", data_ready); end
    tick();
    checks++; if (out_flit !== {2'b10, 1'b0, 32'h5B}) begin errors++; $display("FAIL bp_tail: got %h expected %h", out_flit, {2'b10, 1'b0, 32'h5B}); end
    data_valid = 1'b0;
    tick();
    checks++; if (acc_cnt - a0 !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", acc_cnt - a0); end
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = acc_cnt;
    msg_valid = 1'b1; msg_dst_x = 2'd2; msg_dst_y = 2'd2; msg_len = 4'd1;
    data_valid = 1'b1; data = 32'h77;
    tick();
    tick();
    checks++; if (out_flit !== {2'b01, 1'b0, 32'h0000_011A}) begin errors++; $display("FAIL b2b_head1: got %h expected %h", out_flit, {2'b01, 1'b0, 32'h0000_011A}); end
    checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", msg_ready); end
    tick();
    checks++; if (out_flit !== {2'b10, 1'b0, 32'h77}) begin errors++; $display("FAIL b2b_tail1: got %h expected %h", out_flit, {2'b10, 1'b0, 32'h77}); end
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b expected 1", msg_ready); end
    data = 32'h88;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %b expected 0", out_valid); end
    msg_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_flit !== {2'b01, 1'b0, 32'h0000_011A}) begin errors++; $display("FAIL b2b_head2: got v=%b %h expected v=1 %h", out_valid, out_flit, {2'b01, 1'b0, 32'h0000_011A}); end
    tick();
    checks++; if (out_flit !== {2'b10, 1'b0, 32'h88}) begin errors++; $display("FAIL b2b_tail2: got %h expected %h", out_flit, {2'b10, 1'b0, 32'h88}); end
    data_valid = 1'b0;
    tick();
    checks++; if (acc_cnt - a0 !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", acc_cnt - a0); end
  endtask

  task automatic test_reset_mid();
    msg_valid = 1'b1; msg_dst_x = 2'd3; msg_dst_y = 2'd3; msg_len = 4'd4;
    tick();
    msg_valid = 1'b0;
    data_valid = 1'b1; data = 32'h1;
    tick();
    tick();
    data = 32'h2;
    tick();
    checks++; if (out_flit !== {2'b00, 1'b0, 32'h2}) begin errors++; $display("FAIL rm_body2: got %h expected %h", out_flit, {2'b00, 1'b0, 32'h2}); end
    noc_rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
    checks++; if (out_flit !== '0) begin errors++; $display("FAIL rm_flit: got %h expected 0", out_flit); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rm_data_ready: got %b expected 0", data_ready); end
    noc_rst = 1'b0; data_valid = 1'b0;
    #1;
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL rm_msg_ready: got %b expected 1", msg_ready); end
    msg_valid = 1'b1; msg_dst_x = 2'd0; msg_dst_y = 2'd1; msg_len = 4'd1;
    data_valid = 1'b1; data = 32'h99;
    tick();
    msg_valid = 1'b0;
    tick();
    checks++; if (out_flit !== {2'b01, 1'b0, 32'h0000_0114}) begin errors++; $display("FAIL rm_fresh_head: got %h expected %h", out_flit, {2'b01, 1'b0, 32'h0000_0114}); end
    tick();
    checks++; if (out_flit !== {2'b10, 1'b0, 32'h99}) begin errors++; $display("FAIL rm_fresh_tail: got %h expected %h", out_flit, {2'b10, 1'b0, 32'h99}); end
    data_valid = 1'b0;
    tick();
  endtask

  initial begin
    id_x = 2'd1;
    id_y = 2'd0;
    test_reset();
    test_zero_len();
    test_three_word();
    test_vc_select();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
